cache_repl_ctrl: RTL

- Replacement controller for a set-associative cache.
- Owns a per-set tree-PLRU state table and updates it on hits.
- On misses, selects a victim way: first invalid way, else the PLRU way. Holds the victim until the refill engine signals completion, then marks the victim most-recently-used.
- Sits between the cache tag-compare stage and the refill FSM; one outstanding miss at a time.

---
 rtl/cache_repl_pkg.sv | 51 +++++
 rtl/cache_repl_ctrl_plru_tree_fn.sv | 31 +++
 rtl/cache_repl_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cache_repl_pkg.sv
// Shared types and tree-PLRU helpers for the cache replacement controller.
package cache_repl_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        WAIT
    } repl_state_e;

    // Victim way of a tree-PLRU entry; entries are carried as 3 bits, 2-way uses s[0] only.
    function automatic logic [1:0] plru_victim(input logic [2:0] s, input int unsigned assoc);
        logic [1:0] v;
        if (assoc == 2) begin
            v = {1'b0, s[0]};
        end else begin
            v = s[2] ? {1'b1, s[0]} : {1'b0, s[1]};
        end
        return v;
    endfunction

    // Entry after an access to 'way': bits on the accessed path point away from it.
    function automatic logic [2:0] plru_touch(input logic [2:0] s, input logic [1:0] way,
                                              input int unsigned assoc);
        logic [2:0] n;
        n = s;
        if (assoc == 2) begin
            n[0] = ~way[0];
        end else begin
            case (way)
                2'd3:    begin n[2] = 1'b0; n[0] = 1'b0; end
                2'd2:    begin n[2] = 1'b0; n[0] = 1'b1; end
                2'd1:    begin n[2] = 1'b1; n[1] = 1'b0; end
                default: begin n[2] = 1'b1; n[1] = 1'b1; end
            endcase
        end
        return n;
    endfunction

    // Lowest-index invalid way as {found, way}.
    function automatic logic [2:0] first_invalid(input logic [3:0] valid);
        logic [2:0] r;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!valid[i] && !r[2]) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_repl_ctrl_plru_tree_fn.sv
// Combinational tree-PLRU decode/update for one table entry.
module plru_tree_fn
    import cache_repl_pkg::*;
#(
    parameter int unsigned ASSOC_NUM = 4,
    localparam int unsigned WAY_W = $clog2(ASSOC_NUM),
    localparam int unsigned TB_W  = ASSOC_NUM - 1
) (
    input  logic [TB_W-1:0]      entry,
    input  logic [ASSOC_NUM-1:0] access,
    output logic [TB_W-1:0]      next_entry,
    output logic [WAY_W-1:0]     victim
);

    logic [1:0] idx;
    logic [2:0] s;

    // Convert the one-hot access to an index, then decode and update the tree.
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < ASSOC_NUM; i++) begin
            if (access[i]) begin
                idx = 2'(i);
            end
        end
        s          = 3'(entry);
        next_entry = TB_W'(plru_touch(s, idx, ASSOC_NUM));
        victim     = WAY_W'(plru_victim(s, ASSOC_NUM));
    end

endmodule

// File: rtl/cache_repl_ctrl.sv
// Replacement controller: per-set tree-PLRU table, victim selection, refill handshake.
module cache_repl_ctrl
    import cache_repl_pkg::*;
#(
    parameter int unsigned SET_NUM   = 64,
    parameter int unsigned ASSOC_NUM = 4,
    localparam int unsigned IDX_W = $clog2(SET_NUM),
    localparam int unsigned WAY_W = $clog2(ASSOC_NUM)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [IDX_W-1:0]     req_set,
    input  logic                 req_hit,
    input  logic [ASSOC_NUM-1:0] req_hit_way,
    input  logic [ASSOC_NUM-1:0] req_line_valid,
    output logic                 vic_valid,
    output logic [IDX_W-1:0]     vic_set,
    output logic [WAY_W-1:0]     vic_way,
    input  logic                 refill_done
);

    localparam int unsigned TB_W = ASSOC_NUM - 1;

    repl_state_e          state, state_nxt;
    logic [TB_W-1:0]      plru_tbl [SET_NUM];
    logic [IDX_W-1:0]     cnt;

    logic [IDX_W-1:0]     rd_set;
    logic [TB_W-1:0]      rd_entry;
    logic [ASSOC_NUM-1:0] acc;
    logic [TB_W-1:0]      tree_next;
    logic [WAY_W-1:0]     tree_victim;
    logic [3:0]           valid_pad;
    logic [2:0]           fi;
    logic [WAY_W-1:0]     miss_way;

    logic                 tbl_we;
    logic [IDX_W-1:0]     tbl_widx;
    logic [TB_W-1:0]      tbl_wdata;
    logic                 vic_load;
    logic                 cnt_clr;

    // One tree instance serves both paths: WAIT reads the pending set and touches
    // the victim, otherwise the looked-up set is read and touched with the hit way.
    always_comb begin
        rd_set   = (state == WAIT) ? vic_set : req_set;
        rd_entry = plru_tbl[rd_set];
        acc      = (state == WAIT) ? (ASSOC_NUM'(1) << vic_way) : req_hit_way;
        valid_pad = '1;
        valid_pad[ASSOC_NUM-1:0] = req_line_valid;
        fi       = first_invalid(valid_pad);
        miss_way = fi[2] ? WAY_W'(fi[1:0]) : tree_victim;
    end

    plru_tree_fn #(.ASSOC_NUM(ASSOC_NUM)) u_tree (
        .entry      (rd_entry),
        .access     (acc),
        .next_entry (tree_next),
        .victim     (tree_victim)
    );

    // Next-state and control decode.
    always_comb begin
        state_nxt = state;
        tbl_we    = 1'b0;
        tbl_widx  = rd_set;
        tbl_wdata = tree_next;
        vic_load  = 1'b0;
        cnt_clr   = 1'b0;
        req_ready = (state == IDLE);
        vic_valid = (state == WAIT);
        case (state)
            INIT: begin
                tbl_we    = 1'b1;
                tbl_widx  = cnt;
                tbl_wdata = '0;
                if (cnt == IDX_W'(SET_NUM - 1)) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (flush) begin
                    state_nxt = INIT;
                    cnt_clr   = 1'b1;
                end else if (req_valid) begin
                    if (req_hit) begin
                        tbl_we = 1'b1;
                    end else begin
                        vic_load  = 1'b1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (refill_done) begin
                    tbl_we    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Sweep counter and pending victim registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            vic_set <= '0;
            vic_way <= '0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (state == INIT) begin
                cnt <= cnt + 1'b1;
            end
            if (vic_load) begin
                vic_set <= req_set;
                vic_way <= miss_way;
            end
        end
    end

    // PLRU table write port; contents are cleared by the INIT sweep, not by reset.
    always_ff @(posedge clk) begin
        if (tbl_we && !reset) begin
            plru_tbl[tbl_widx] <= tbl_wdata;
        end
    end

    hit_way_onehot: assert property (@(posedge clk) disable iff (reset)
        (req_valid && req_ready && req_hit) |-> $onehot(req_hit_way));

endmodule
